// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - registered N-operand bitwise logic stage with valid/ready handshake
// Optional feature macro: LOGIC_GATE_UNIT_REDUCE_EN (adds out_all_ones / out_zero flags)
module logic_gate_unit #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2   // legal range 2..8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    output logic                    out_all_ones,
    output logic                    out_zero,
`endif
    output logic                    out_err
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    logic [WIDTH-1:0] and_r, or_r, xor_r;
    logic [WIDTH-1:0] result;
    logic             result_err;
    logic             accept;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;

    // Reduce all operands per bit into the three base functions
    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            and_r = and_r & in_data[k*WIDTH +: WIDTH];
            or_r  = or_r  | in_data[k*WIDTH +: WIDTH];
            xor_r = xor_r ^ in_data[k*WIDTH +: WIDTH];
        end
    end

    // Select the requested function; illegal codes give a zero result flagged as error
    always_comb begin
        result     = '0;
        result_err = 1'b0;
        case (in_op)
            OP_AND:  result = and_r;
            OP_OR:   result = or_r;
            OP_XOR:  result = xor_r;
            OP_NAND: result = ~and_r;
            OP_NOR:  result = ~or_r;
            OP_XNOR: result = ~xor_r;
            default: result_err = 1'b1;
        endcase
    end

    // Single-entry pipeline: accept whenever the slot is empty or draining this cycle
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Next state of the result register; inputs are only looked at on accept
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = result;
            err_d   = result_err;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Result register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_err   = err_q;

`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    logic all_ones_q, all_ones_d;
    logic zero_q, zero_d;

    // Reduction flags follow the result register and are suppressed on error
    always_comb begin
        all_ones_d = all_ones_q;
        zero_d     = zero_q;
        if (accept) begin
            all_ones_d = !result_err && (&result);
            zero_d     = !result_err && !(|result);
        end
    end

    // Reduction flag registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_ones_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            all_ones_q <= all_ones_d;
            zero_q     <= zero_d;
        end
    end

    assign out_all_ones = all_ones_q;
    assign out_zero     = zero_q;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// tb/tb_logic_gate_unit.sv - randomized and directed self-checking bench for logic_gate_unit
module tb_logic_gate_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: default 8-bit, 2 operands
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [2:0]  a_in_op;
    logic [15:0] a_in_data;
    logic [7:0]  a_out_data;
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    logic        a_all_ones, a_zero, b_all_ones, b_zero;
`endif

    // DUT B: 16-bit, 4 operands
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [2:0]  b_in_op;
    logic [63:0] b_in_data;
    logic [15:0] b_out_data;

    logic_gate_unit #(.WIDTH(8), .NUM_IN(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        .out_all_ones(a_all_ones), .out_zero(a_zero),
`endif
        .out_err(a_out_err)
    );

    logic_gate_unit #(.WIDTH(16), .NUM_IN(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        .out_all_ones(b_all_ones), .out_zero(b_zero),
`endif
        .out_err(b_out_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: count ones per bit position, derive the function from the count
    function automatic logic [16:0] gate_model(input int w, input int n,
                                               input logic [2:0] op, input logic [63:0] d);
        logic [15:0] r;
        int cnt;
        logic b;
        r = '0;
        if (op > 3'd5) return {1'b1, 16'h0};
        for (int i = 0; i < w; i++) begin
            cnt = 0;
            for (int k = 0; k < n; k++) cnt += int'(d[k*w + i]);
            case (op)
                3'd0:    b = (cnt == n);
                3'd1:    b = (cnt > 0);
                3'd2:    b = (cnt % 2) == 1;
                3'd3:    b = (cnt != n);
                3'd4:    b = (cnt == 0);
                default: b = (cnt % 2) == 0;
            endcase
            r[i] = b;
        end
        return {1'b0, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic basic_and(input string tag);
        a_in_valid  = 1'b1;
        a_in_op     = 3'd0;
        a_in_data   = {8'hF0, 8'h3C};
        a_out_ready = 1'b1;
        step();
        check({tag, "_valid"}, 32'(a_out_valid), 32'd1);
        check({tag, "_data"},  32'(a_out_data),  32'h30);
        check({tag, "_err"},   32'(a_out_err),   32'd0);
        a_in_valid = 1'b0;
        step();
        check({tag, "_drain"}, 32'(a_out_valid), 32'd0);
    endtask

    logic [7:0]  fn_exp [6];
    logic [16:0] m;
    logic [63:0] d64;
    logic [8:0]  sb [$];
    logic        pending, acc, fire;

    initial begin
        fn_exp = '{8'h0A, 8'hAF, 8'hA5, 8'hF5, 8'h50, 8'h5A};
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_op = 3'd0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_op = 3'd0; b_in_data = '0; b_out_ready = 1'b0;

        // Reset
        repeat (2) step();
        check("rst_valid", 32'(a_out_valid), 32'd0);
        check("rst_data",  32'(a_out_data),  32'd0);
        check("rst_err",   32'(a_out_err),   32'd0);
        check("rst_b_valid", 32'(b_out_valid), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(a_in_ready), 32'd1);

        basic_and("basic");

        // All legal functions on AA / 0F
        a_out_ready = 1'b1;
        for (int op = 0; op < 6; op++) begin
            a_in_valid = 1'b1;
            a_in_op    = 3'(op);
            a_in_data  = {8'hAA, 8'h0F};
            step();
            m = gate_model(8, 2, 3'(op), 64'(a_in_data));
            check($sformatf("fn%0d_tab", op), 32'(a_out_data), 32'(fn_exp[op]));
            check($sformatf("fn%0d_mdl", op), 32'(a_out_data), 32'(m[7:0]));
            check($sformatf("fn%0d_valid", op), 32'(a_out_valid), 32'd1);
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
            check($sformatf("fn%0d_ones", op), 32'(a_all_ones), 32'(fn_exp[op] == 8'hFF));
            check($sformatf("fn%0d_zero", op), 32'(a_zero),     32'(fn_exp[op] == 8'h00));
`endif
        end

        // Illegal op, then a legal op clears the error
        a_in_op   = 3'd6;
        a_in_data = 16'($urandom);
        step();
        check("ill_data",  32'(a_out_data),  32'h00);
        check("ill_err",   32'(a_out_err),   32'd1);
        check("ill_valid", 32'(a_out_valid), 32'd1);
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        check("ill_zero", 32'(a_zero), 32'd0);
`endif
        a_in_op   = 3'd1;
        a_in_data = {8'hAA, 8'h0F};
        step();
        check("ill_clr_err",  32'(a_out_err),  32'd0);
        check("ill_clr_data", 32'(a_out_data), 32'hAF);
        a_in_valid = 1'b0;
        step();
        check("ill_drain", 32'(a_out_valid), 32'd0);

        // Back-pressure: hold A5 while a new set waits
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_op     = 3'd2;
        a_in_data   = {8'hAA, 8'h0F};
        step();
        a_in_op   = 3'd0;
        a_in_data = {8'hFF, 8'hFF};
        for (int c = 0; c < 3; c++) begin
            check("bp_in_ready", 32'(a_in_ready), 32'd0);
            step();
            check("bp_data",  32'(a_out_data),  32'hA5);
            check("bp_valid", 32'(a_out_valid), 32'd1);
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(a_in_ready), 32'd1);
        step();
        a_in_valid = 1'b0;
        check("bp_new_data",  32'(a_out_data),  32'hFF);
        check("bp_new_valid", 32'(a_out_valid), 32'd1);
        step();
        check("bp_no_dup", 32'(a_out_valid), 32'd0);

        // Throughput on B: 16 back-to-back 4-way XOR transfers
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_op     = 3'd2;
        for (int t = 0; t < 16; t++) begin
            d64 = {$urandom, $urandom};
            b_in_data = d64;
            step();
            m = gate_model(16, 4, 3'd2, d64);
            check($sformatf("tp%0d_valid", t), 32'(b_out_valid), 32'd1);
            check($sformatf("tp%0d_data", t),  32'(b_out_data),  32'(m[15:0]));
        end
        b_in_valid = 1'b0;
        step();
        check("tp_drain", 32'(b_out_valid), 32'd0);

        // Randomized traffic on A against a scoreboard
        pending = 1'b0;
        a_in_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            if (!pending) begin
                a_in_valid = ($urandom_range(0, 2) != 0);
                a_in_op    = 3'($urandom_range(0, 7));
                a_in_data  = 16'($urandom);
            end
            a_out_ready = ($urandom_range(0, 3) != 0);
            #4;
            check("rnd_valid", 32'(a_out_valid), 32'(sb.size() != 0));
            if (a_out_valid && sb.size() != 0) begin
                check("rnd_data", 32'(a_out_data), 32'(sb[0][7:0]));
                check("rnd_err",  32'(a_out_err),  32'(sb[0][8]));
            end
            fire = a_out_valid && a_out_ready;
            acc  = a_in_valid && a_in_ready;
            if (fire && sb.size() != 0) void'(sb.pop_front());
            if (acc) begin
                m = gate_model(8, 2, a_in_op, 64'(a_in_data));
                sb.push_back({m[16], m[7:0]});
            end
            pending = a_in_valid && !acc;
        end
        step();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        repeat (2) step();

        // Reset while a result is held under back-pressure
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_op     = 3'd0;
        a_in_data   = {8'hFF, 8'h0F};
        step();
        a_in_valid = 1'b0;
        check("mid_loaded", 32'(a_out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid", 32'(a_out_valid), 32'd0);
        check("mid_data",  32'(a_out_data),  32'd0);
        check("mid_err",   32'(a_out_err),   32'd0);
        step();
        #2;
        rst_n = 1'b1;
        step();
        check("mid_in_ready", 32'(a_in_ready), 32'd1);
        basic_and("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
